// File: rtl/ttl201_access_arbiter.sv
// rtl/ttl201_access_arbiter.sv - two-port round-robin request/ack front end for a 74x201-style RAM
// Optional power-up clear sweep of the whole RAM: define TTL201_INIT_CLEAR_EN
module ttl201_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  busy_o,
    output logic                  ram_s_n_o,
    output logic                  ram_r_w_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic [DATA_WIDTH-1:0] ram_d_o,
    input  logic [DATA_WIDTH-1:0] ram_q_n_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE, ST_CLEAR} state_t;

`ifdef TTL201_INIT_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
    localparam logic   RST_BUSY  = 1'b1;
    logic [ADDR_WIDTH:0] clr_cnt_q, clr_cnt_d;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;   // 1: requester 1 wins a tie
    logic                  gnt_q, gnt_d;
    logic                  rd_q, rd_d;
    logic                  s_n_q, s_n_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;

    logic                  elig0, elig1, pick, pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    // A requester whose ack is showing is skipped so its trailing req is not re-granted.
    assign elig0      = req0_i & ~ack0_q;
    assign elig1      = req1_i & ~ack1_q;
    assign pick       = (elig0 & elig1) ? prio_q : elig1;
    assign pick_we    = pick ? we1_i : we0_i;
    assign pick_addr  = pick ? addr1_i : addr0_i;
    assign pick_wdata = pick ? wdata1_i : wdata0_i;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        rd_d     = rd_q;
        s_n_d    = s_n_q;
        rw_d     = rw_q;
        a_d      = a_q;
        d_d      = d_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;
`ifdef TTL201_INIT_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    gnt_d   = pick;
                    prio_d  = ~pick;
                    rd_d    = ~pick_we;
                    s_n_d   = 1'b0;
                    rw_d    = ~pick_we;
                    a_d     = pick_addr;
                    d_d     = pick_we ? pick_wdata : '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                s_n_d   = 1'b1;
                rw_d    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    if (rd_q) rdata1_d = ~ram_q_n_i;
                end else begin
                    ack0_d = 1'b1;
                    if (rd_q) rdata0_d = ~ram_q_n_i;
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
`ifdef TTL201_INIT_CLEAR_EN
                if (!clr_cnt_q[ADDR_WIDTH]) begin
                    s_n_d     = 1'b0;
                    rw_d      = 1'b0;
                    a_d       = clr_cnt_q[ADDR_WIDTH-1:0];
                    d_d       = '0;
                    clr_cnt_d = clr_cnt_q + (ADDR_WIDTH+1)'(1);
                end else begin
                    s_n_d   = 1'b1;
                    rw_d    = 1'b1;
                    a_d     = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            rd_q     <= 1'b0;
            s_n_q    <= 1'b1;
            rw_q     <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= RST_BUSY;
`ifdef TTL201_INIT_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            rd_q     <= rd_d;
            s_n_q    <= s_n_d;
            rw_q     <= rw_d;
            a_q      <= a_d;
            d_q      <= d_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
`ifdef TTL201_INIT_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    assign ack0_o    = ack0_q;
    assign ack1_o    = ack1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;
    assign busy_o    = busy_q;
    assign ram_s_n_o = s_n_q;
    assign ram_r_w_o = rw_q;
    assign ram_a_o   = a_q;
    assign ram_d_o   = d_q;

endmodule

// File: tb/tb_ttl201_access_arbiter.sv
// tb/tb_ttl201_access_arbiter.sv - directed self-checking bench for ttl201_access_arbiter
module tb_ttl201_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic       wdata0 = 1'b0, wdata1 = 1'b0;
    logic       ack0, ack1, rdata0, rdata1, busy;
    logic       ram_s_n, ram_r_w, ram_d;
    logic [7:0] ram_a;
    logic       ram_q_n = 1'b1;
    logic       mem [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int sel_cnt, busy_cnt;
    int ev_port[$];
    int ev_cyc[$];
    logic ev_rd[$];
    logic ev_qn[$];

`ifdef TTL201_INIT_CLEAR_EN
    localparam logic EXP_RST_BUSY = 1'b1;
`else
    localparam logic EXP_RST_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    ttl201_access_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_i    (req0),
        .req1_i    (req1),
        .we0_i     (we0),
        .we1_i     (we1),
        .addr0_i   (addr0),
        .addr1_i   (addr1),
        .wdata0_i  (wdata0),
        .wdata1_i  (wdata1),
        .ack0_o    (ack0),
        .ack1_o    (ack1),
        .rdata0_o  (rdata0),
        .rdata1_o  (rdata1),
        .busy_o    (busy),
        .ram_s_n_o (ram_s_n),
        .ram_r_w_o (ram_r_w),
        .ram_a_o   (ram_a),
        .ram_d_o   (ram_d),
        .ram_q_n_i (ram_q_n)
    );

    // 74x201 model: synchronous write, registered inverted read data
    initial for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    always @(posedge clk) begin
        if (!ram_s_n) begin
            if (!ram_r_w) mem[ram_a] <= ram_d;
            else          ram_q_n    <= ~mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int evp(input int i);
        return (i < ev_port.size()) ? ev_port[i] : 99;
    endfunction

    function automatic int evc(input int i);
        return (i < ev_cyc.size()) ? ev_cyc[i] : 999;
    endfunction

    function automatic logic evr(input int i);
        return (i < ev_rd.size()) ? ev_rd[i] : 1'bx;
    endfunction

    task automatic clr_ev();
        ev_port.delete(); ev_cyc.delete(); ev_rd.delete(); ev_qn.delete();
        sel_cnt = 0; busy_cnt = 0;
    endtask

    // Runs ncyc cycles from just after a rising edge; logs acks per falling edge.
    task automatic run(input int ncyc, input bit drop);
        bit d0, d1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!ram_s_n) sel_cnt++;
            if (busy) busy_cnt++;
            if (ack0) begin ev_port.push_back(0); ev_cyc.push_back(i); ev_rd.push_back(rdata0); ev_qn.push_back(ram_q_n); end
            if (ack1) begin ev_port.push_back(1); ev_cyc.push_back(i); ev_rd.push_back(rdata1); ev_qn.push_back(ram_q_n); end
            d0 = drop & ack0;
            d1 = drop & ack1;
            @(posedge clk); #1;
            if (d0) req0 = 1'b0;
            if (d1) req1 = 1'b0;
        end
    endtask

    task automatic acc(input string tag, input int p, input bit we, input logic [7:0] a,
                       input bit wd, input logic exp_rd);
        if (p == 0) begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        else        begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        clr_ev();
        run(8, 1'b1);
        chk({tag, "_nacks"}, ev_port.size(), 1);
        chk({tag, "_port"}, evp(0), p);
        chk({tag, "_lat"}, evc(0), 3);
        chk({tag, "_sel"}, sel_cnt, 1);
        if (!we) chk({tag, "_rdata"}, evr(0), exp_rd);
        else     chk({tag, "_mem"}, mem[a], wd);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(posedge clk); #1;
        chk("ready_busy", busy, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_n", ram_s_n, 1);
        chk("rst_r_w", ram_r_w, 1);
        chk("rst_a", ram_a, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        chk("rst_busy", busy, EXP_RST_BUSY);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wait_ready();

        acc("wr5a", 0, 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("wr_keeps_rdata0", rdata0, 0);
        acc("rd5a", 1, 1'b0, 8'h5A, 1'b0, 1'b1);
        chk("rd5a_rdata1_hold", rdata1, 1);

        acc("wr10", 1, 1'b1, 8'h10, 1'b0, 1'b0);
        acc("rd10", 0, 1'b0, 8'h10, 1'b0, 1'b0);
        chk("rd10_qn", (ev_qn.size() > 0) ? ev_qn[0] : 1'bx, 1);
        chk("wr10_keeps_rdata1", rdata1, 1);

        acc("wrff", 0, 1'b1, 8'hFF, 1'b1, 1'b0);
        acc("wr00", 0, 1'b1, 8'h00, 1'b0, 1'b0);
        acc("rdff", 0, 1'b0, 8'hFF, 1'b0, 1'b1);
        acc("rd00", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Arbitration from a fresh reset: requester 0 wins the first tie.
        pulse_reset();
        wait_ready();
        for (int k = 0; k < 2; k++) begin
            we0 = 1'b0; addr0 = 8'h01; req0 = 1'b1;
            we1 = 1'b0; addr1 = 8'h02; req1 = 1'b1;
            clr_ev();
            run(12, 1'b1);
            chk("pair_nacks", ev_port.size(), 2);
            chk("pair_first", evp(0), 0);
            chk("pair_second", evp(1), 1);
            chk("pair_lat0", evc(0), 3);
            chk("pair_lat1", evc(1), 6);
        end

        req0 = 1'b1; req1 = 1'b1;
        clr_ev();
        run(14, 1'b0);
        chk("hold_nacks", ev_port.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("hold_port", evp(k), k % 2);
            chk("hold_cyc", evc(k), 3 + 3 * k);
        end
        req0 = 1'b0; req1 = 1'b0;
        run(6, 1'b0);

        // Reset while the RAM select is asserted.
        we0 = 1'b0; addr0 = 8'hFF; req0 = 1'b1;
        @(posedge clk); #1;
        chk("mid_sel_low", ram_s_n, 0);
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("mid_s_n", ram_s_n, 1);
        chk("mid_ack", ack0, 0);
        chk("mid_busy", busy, EXP_RST_BUSY);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef TTL201_INIT_CLEAR_EN
        we0 = 1'b0; addr0 = 8'hFF; req0 = 1'b1;
        clr_ev();
        run(256, 1'b1);
        chk("clr_busy_cycles", busy_cnt, 256);
        chk("clr_no_ack", ev_port.size(), 0);
        clr_ev();
        run(12, 1'b1);
        chk("clr_nacks", ev_port.size(), 1);
        chk("clr_lat", evc(0), 3);
        chk("clr_rdff", evr(0), 0);
`else
        clr_ev();
        run(8, 1'b1);
        chk("post_rst_no_ack", ev_port.size(), 0);
        chk("post_rst_busy", busy_cnt, 0);
        acc("post_rdff", 0, 1'b0, 8'hFF, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
